// File: rtl/winocnn_pkg.sv
// Shared constants, loader state encoding and the line-count clamp used by the scan stream loader.
package winocnn_pkg;

    localparam int BEAT_W = 32;
    localparam int LINE_W = 512;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 128;
    localparam int BPL    = LINE_W / BEAT_W;
    localparam int CNT_W  = $clog2(BPL);

    typedef enum logic [2:0] {
        IDLE,
        FILL_D,
        FILL_W,
        WRITE,
        DONE
    } loader_state_t;

    function automatic logic [ADDR_W-1:0] clamp_lines(input logic [ADDR_W-1:0] n);
        return (n > ADDR_W'(DEPTH)) ? ADDR_W'(DEPTH) : n;
    endfunction

endpackage

// File: rtl/scan_stream_loader_line_packer.sv
// line_packer: collects BPL beats into one LINE_W line, beat k in bits [k*BEAT_W +: BEAT_W].
// last_beat flags the accept that completes the line; the counter wraps for the next line.
module line_packer
    import winocnn_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [BEAT_W-1:0] beat,
    output logic [LINE_W-1:0] line,
    output logic              last_beat
);

    logic [CNT_W-1:0] cnt;

    assign last_beat = load && (cnt == CNT_W'(BPL - 1));

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            cnt  <= '0;
            line <= '0;
        end else if (load) begin
            line[cnt*BEAT_W +: BEAT_W] <= beat;
            cnt                        <= last_beat ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/scan_stream_loader.sv
// scan_stream_loader: packs a beat stream into data/weight line pairs, writes one pair per scan
// address, then pulses load_done. Optional XOR checksum of accepted beats under LOADER_CHECKSUM_EN.
module scan_stream_loader
    import winocnn_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start_load,
    input  logic [ADDR_W-1:0] num_lines,
    input  logic              s_valid,
    input  logic [BEAT_W-1:0] s_data,
    output logic              s_ready,
    output logic              input_mem_scan_mode,
    output logic [ADDR_W-1:0] scan_addr,
    output logic [LINE_W-1:0] data_mem_scan_in,
    output logic [LINE_W-1:0] weight_mem_scan_in,
    output logic              busy,
    output logic              load_done,
    output logic [BEAT_W-1:0] checksum
);

    loader_state_t     state, state_nxt;
    logic [ADDR_W-1:0] lines_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] addr_q;
    logic              start_acc;
    logic              beat_fire;
    logic              last_idx;
    logic              d_last, w_last;

    assign start_acc = (state == IDLE) && start_load;
    assign beat_fire = s_valid && s_ready;
    assign last_idx  = (idx_q == lines_q - ADDR_W'(1));
    assign scan_addr = addr_q;

    always_comb begin
        state_nxt           = state;
        s_ready             = 1'b0;
        input_mem_scan_mode = 1'b0;
        busy                = 1'b1;
        load_done           = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start_load) state_nxt = (num_lines == '0) ? DONE : FILL_D;
            end
            FILL_D: begin
                s_ready = 1'b1;
                if (d_last) state_nxt = FILL_W;
            end
            FILL_W: begin
                s_ready = 1'b1;
                if (w_last) state_nxt = WRITE;
            end
            WRITE: begin
                input_mem_scan_mode = 1'b1;
                state_nxt           = last_idx ? DONE : FILL_D;
            end
            DONE: begin
                load_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            lines_q <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
        end else begin
            state <= state_nxt;
            if (start_acc) begin
                lines_q <= clamp_lines(num_lines);
                idx_q   <= '0;
            end
            // Latch the address on the final weight beat so it holds after the strobe.
            if (state == FILL_W && w_last) addr_q <= idx_q;
            if (state == WRITE && !last_idx) idx_q <= idx_q + ADDR_W'(1);
        end
    end

    line_packer u_data_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_acc),
        .load      (beat_fire && state == FILL_D),
        .beat      (s_data),
        .line      (data_mem_scan_in),
        .last_beat (d_last)
    );

    line_packer u_weight_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_acc),
        .load      (beat_fire && state == FILL_W),
        .beat      (s_data),
        .line      (weight_mem_scan_in),
        .last_beat (w_last)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [BEAT_W-1:0] csum_q;

    always_ff @(posedge clk) begin
        if (!reset || start_acc) csum_q <= '0;
        else if (beat_fire)      csum_q <= csum_q ^ s_data;
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_scan_stream_loader.sv
// Randomised bench for scan_stream_loader: writes and checksum are predicted from the beat list.
module tb_scan_stream_loader;
    import winocnn_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              start_load;
    logic [ADDR_W-1:0] num_lines;
    logic              s_valid;
    logic [BEAT_W-1:0] s_data;
    logic              s_ready;
    logic              input_mem_scan_mode;
    logic [ADDR_W-1:0] scan_addr;
    logic [LINE_W-1:0] data_mem_scan_in;
    logic [LINE_W-1:0] weight_mem_scan_in;
    logic              busy;
    logic              load_done;
    logic [BEAT_W-1:0] checksum;

    always #5 clk = ~clk;

    scan_stream_loader dut (
        .clk                 (clk),
        .reset               (reset),
        .start_load          (start_load),
        .num_lines           (num_lines),
        .s_valid             (s_valid),
        .s_data              (s_data),
        .s_ready             (s_ready),
        .input_mem_scan_mode (input_mem_scan_mode),
        .scan_addr           (scan_addr),
        .data_mem_scan_in    (data_mem_scan_in),
        .weight_mem_scan_in  (weight_mem_scan_in),
        .busy                (busy),
        .load_done           (load_done),
        .checksum            (checksum)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] d;
        logic [LINE_W-1:0] w;
    } wr_t;

    logic [BEAT_W-1:0] beats[$];
    wr_t               wr_q[$];
    int                done_cnt;
    int                ready_cnt;

    always @(negedge clk) begin
        wr_t t;
        if (input_mem_scan_mode) begin
            t.a = scan_addr;
            t.d = data_mem_scan_in;
            t.w = weight_mem_scan_in;
            wr_q.push_back(t);
        end
        if (load_done) done_cnt++;
        if (s_ready)   ready_cnt++;
    end

    task automatic check_idle_zero(input string tag);
        check_val({tag, "_ready"}, s_ready, 0);
        check_val({tag, "_strobe"}, input_mem_scan_mode, 0);
        check_val({tag, "_addr"}, scan_addr, 0);
        check_val({tag, "_data"}, data_mem_scan_in, 0);
        check_val({tag, "_weight"}, weight_mem_scan_in, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, load_done, 0);
        check_val({tag, "_csum"}, checksum, 0);
    endtask

    // Drives n beats from the beat list; returns right after the edge that accepted the last one.
    task automatic stream(input int n, input int gap_pct, input bit spur);
        int i = 0;
        int budget = 200 * n + 50;
        while (i < n && budget > 0) begin
            bit acc;
            @(negedge clk);
            s_valid = ($urandom_range(99) >= gap_pct);
            s_data  = s_valid ? beats[i] : $urandom;
            if (spur) begin
                start_load = ($urandom_range(3) == 0);
                num_lines  = ADDR_W'($urandom);
            end
            acc = s_valid && s_ready;
            @(posedge clk);
            if (acc) i++;
            budget--;
        end
        if (i < n) check_val("stream_timeout", i, n);
        @(negedge clk);
        s_valid    = 1'b0;
        start_load = 1'b0;
    endtask

    // mode 0: random beats, 1: beat j = j, 2: all A5 with one 0000FFFF
    task automatic run_load(input int n_req, input int gap_pct, input bit spur, input int mode);
        int n = (n_req > DEPTH) ? DEPTH : n_req;
        int nb = 2 * BPL * n;
        int pos = $urandom_range(nb > 0 ? nb - 1 : 0);
        logic [BEAT_W-1:0] csum = '0;
        wr_q.delete();
        beats.delete();
        done_cnt  = 0;
        ready_cnt = 0;
        for (int j = 0; j < nb; j++) begin
            logic [BEAT_W-1:0] b;
            if (mode == 1)      b = BEAT_W'(j);
            else if (mode == 2) b = (j == pos) ? 32'h0000FFFF : 32'hA5A5A5A5;
            else                b = $urandom;
            beats.push_back(b);
            csum ^= b;
        end
        @(negedge clk);
        start_load = 1'b1;
        num_lines  = ADDR_W'(n_req);
        @(negedge clk);
        start_load = 1'b0;
        check_val("busy_after_start", busy, 1);
        if (n > 0) begin
            check_val("ready_after_start", s_ready, 1);
            stream(nb, gap_pct, spur);
        end
        if (mode == 1) begin
            check_val("strobe_latency", input_mem_scan_mode, 1);
            @(negedge clk);
            check_val("done_latency", load_done, 1);
            check_val("strobe_off_in_done", input_mem_scan_mode, 0);
            @(negedge clk);
            check_val("busy_low_after_done", busy, 0);
        end else begin
            for (int t = 0; t < 8 && done_cnt == 0; t++) @(posedge clk);
            @(negedge clk);
            check_val("busy_low_after_done", busy, 0);
        end
        repeat (3) @(negedge clk);
        check_val("done_count", done_cnt, 1);
        check_val("write_count", wr_q.size(), n);
        if (n == 0) check_val("ready_never", ready_cnt, 0);
        for (int i = 0; i < n && i < wr_q.size(); i++) begin
            logic [LINE_W-1:0] ed, ew;
            for (int k = 0; k < BPL; k++) begin
                ed[k*BEAT_W +: BEAT_W] = beats[2*BPL*i + k];
                ew[k*BEAT_W +: BEAT_W] = beats[2*BPL*i + BPL + k];
            end
            check_val($sformatf("addr_%0d", i), wr_q[i].a, i);
            check_val($sformatf("data_%0d", i), wr_q[i].d, ed);
            check_val($sformatf("weight_%0d", i), wr_q[i].w, ew);
        end
        if (mode == 1 && wr_q.size() > 0) begin
            check_val("data_beat3", wr_q[0].d[3*BEAT_W +: BEAT_W], 32'h3);
            check_val("weight_beat0", wr_q[0].w[BEAT_W-1:0], 32'h10);
        end
`ifdef LOADER_CHECKSUM_EN
        check_val("checksum", checksum, csum);
        if (mode == 2) check_val("checksum_a5", checksum, 32'hA5A55A5A);
`else
        check_val("checksum_off", checksum, 0);
`endif
    endtask

    initial begin
        reset      = 1'b0;
        start_load = 1'b0;
        num_lines  = '0;
        s_valid    = 1'b0;
        s_data     = '0;
        done_cnt   = 0;
        ready_cnt  = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        reset = 1'b1;

        run_load(1, 0, 0, 1);
        run_load(128, 30, 0, 0);
        run_load(0, 0, 0, 0);
        run_load(4, 25, 1, 0);
        run_load(200, 0, 0, 0);
        run_load(1, 20, 0, 2);

        // Abort partway through the data beats of line 5, then reload.
        beats.delete();
        for (int j = 0; j < 2 * BPL * 8; j++) beats.push_back($urandom);
        done_cnt = 0;
        @(negedge clk);
        start_load = 1'b1;
        num_lines  = 8;
        @(negedge clk);
        start_load = 1'b0;
        stream(2 * BPL * 5 + 5, 20, 0);
        check_val("pre_reset_ready", s_ready, 1);
        reset = 1'b0;
        @(negedge clk);
        check_idle_zero("midreset");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_val("midreset_no_done", done_cnt, 0);
        run_load(3, 15, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
